// File: rtl/datapath_types_pkg.sv
// Shared datapath types: prediction result tag and BTB entry layout.
package datapath_types_pkg;

   // Outcome of a resolved prediction, reported to the cpu_tracker
   typedef enum logic [1:0] {
      NA         = 2'b00,
      RIGHT_PRED = 2'b01,
      WRONG_PRED = 2'b10
   } pred_t;

   localparam int unsigned PC_W        = 32;
   localparam int unsigned BTB_ENTRIES = 16;
   localparam int unsigned BTB_IDX_W   = $clog2(BTB_ENTRIES);
   localparam int unsigned BTB_TAG_W   = 30 - BTB_IDX_W;

   // 00 strong NT, 01 weak NT, 10 weak T, 11 strong T
   typedef logic [1:0] btb_ctr_t;

   localparam btb_ctr_t CTR_STRONG_NT = 2'b00;
   localparam btb_ctr_t CTR_WEAK_T    = 2'b10;
   localparam btb_ctr_t CTR_STRONG_T  = 2'b11;

   typedef struct packed {
      logic                  valid;
      logic [BTB_TAG_W-1:0]  tag;
      logic [PC_W-1:0]       target;
      btb_ctr_t              ctr;
   } btb_entry_t;

endpackage

// File: rtl/pred_sat_ctr.sv
// 2-bit saturating direction counter next-state function.
//  ctr    in  current counter value
//  taken  in  resolved branch outcome
//  ctr_n  out counter value after training (combinational)
module pred_sat_ctr
   import datapath_types_pkg::*;
(
   input  btb_ctr_t ctr,
   input  logic     taken,
   output btb_ctr_t ctr_n
);

   // Step toward the outcome, clamping at either end
   always_comb begin
      ctr_n = ctr;
      if (taken) begin
         if (ctr != CTR_STRONG_T) ctr_n = btb_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != CTR_STRONG_NT) ctr_n = btb_ctr_t'(ctr - 2'd1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters for the 5-stage pipeline.
//  CLK, nRST              clock, async active-low reset
//  en                     pipeline advance; gates every state update
//  lk_pc -> lk_hit/lk_taken/lk_npc     combinational fetch lookup
//  up_valid/up_pc/up_taken/up_target/up_pred_npc   execute-stage resolution
//  mispredict, fix_pc     combinational redirect decision
//  pred_result            registered RIGHT_PRED / WRONG_PRED / NA
//  mispred_cnt            registered saturating mispredict count
module branch_predictor
   import datapath_types_pkg::*;
#(
   parameter int unsigned ENTRIES  = BTB_ENTRIES,
   parameter int unsigned TAG_W    = BTB_TAG_W,
   parameter btb_ctr_t    CTR_INIT = 2'b01
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            en,
   input  logic [31:0]     lk_pc,
   output logic            lk_hit,
   output logic            lk_taken,
   output logic [31:0]     lk_npc,
   input  logic            up_valid,
   input  logic [31:0]     up_pc,
   input  logic            up_taken,
   input  logic [31:0]     up_target,
   input  logic [31:0]     up_pred_npc,
   output logic            mispredict,
   output logic [31:0]     fix_pc,
   output pred_t           pred_result,
   output logic [31:0]     mispred_cnt
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   btb_entry_t btb_q [ENTRIES];
   btb_entry_t btb_d [ENTRIES];
   pred_t      pred_result_q, pred_result_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   btb_entry_t       lk_entry, up_entry;
   logic             up_hit;
   btb_ctr_t         up_ctr_n;

   // Byte-offset bits never participate in indexing or tagging
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{lk_pc[1:0], up_pc[1:0]};

   assign lk_idx = lk_pc[IDX_W+1:2];
   assign lk_tag = lk_pc[31:IDX_W+2];
   assign up_idx = up_pc[IDX_W+1:2];
   assign up_tag = up_pc[31:IDX_W+2];

   // Fetch lookup reads pre-edge table state
   always_comb begin
      lk_entry = btb_q[lk_idx];
      lk_hit   = lk_entry.valid && (lk_entry.tag == BTB_TAG_W'(lk_tag));
      lk_taken = lk_hit && lk_entry.ctr[1];
      lk_npc   = lk_taken ? lk_entry.target : 32'(lk_pc + 32'd4);
   end

   // Redirect decision, valid whenever up_valid regardless of en
   always_comb begin
      fix_pc     = up_taken ? up_target : 32'(up_pc + 32'd4);
      mispredict = up_valid && (fix_pc != up_pred_npc);
   end

   pred_sat_ctr u_sat_ctr (
      .ctr   (up_entry.ctr),
      .taken (up_taken),
      .ctr_n (up_ctr_n)
   );

   // Table training: train on hit, allocate only on a taken miss
   always_comb begin
      btb_d    = btb_q;
      up_entry = btb_q[up_idx];
      up_hit   = up_entry.valid && (up_entry.tag == BTB_TAG_W'(up_tag));
      if (en && up_valid) begin
         if (up_hit) begin
            btb_d[up_idx].ctr = up_ctr_n;
            if (up_taken) btb_d[up_idx].target = up_target;
         end else if (up_taken) begin
            btb_d[up_idx].valid  = 1'b1;
            btb_d[up_idx].tag    = BTB_TAG_W'(up_tag);
            btb_d[up_idx].target = up_target;
            btb_d[up_idx].ctr    = CTR_WEAK_T;
         end
      end
   end

   // Result tag and saturating mispredict counter
   always_comb begin
      pred_result_d = pred_result_q;
      mispred_cnt_d = mispred_cnt_q;
      if (en) begin
         if (!up_valid)      pred_result_d = NA;
         else if (mispredict) pred_result_d = WRONG_PRED;
         else                pred_result_d = RIGHT_PRED;
         if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF))
            mispred_cnt_d = 32'(mispred_cnt_q + 32'd1);
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            btb_q[i].valid  <= 1'b0;
            btb_q[i].tag    <= '0;
            btb_q[i].target <= '0;
            btb_q[i].ctr    <= CTR_INIT;
         end
         pred_result_q <= NA;
         mispred_cnt_q <= '0;
      end else begin
         btb_q         <= btb_d;
         pred_result_q <= pred_result_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign pred_result = pred_result_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;
   import datapath_types_pkg::*;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        en;
   logic [31:0] lk_pc;
   logic        lk_hit, lk_taken;
   logic [31:0] lk_npc;
   logic        up_valid, up_taken;
   logic [31:0] up_pc, up_target, up_pred_npc;
   logic        mispredict;
   logic [31:0] fix_pc;
   pred_t       pred_result;
   logic [31:0] mispred_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   branch_predictor dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .en          (en),
      .lk_pc       (lk_pc),
      .lk_hit      (lk_hit),
      .lk_taken    (lk_taken),
      .lk_npc      (lk_npc),
      .up_valid    (up_valid),
      .up_pc       (up_pc),
      .up_taken    (up_taken),
      .up_target   (up_target),
      .up_pred_npc (up_pred_npc),
      .mispredict  (mispredict),
      .fix_pc      (fix_pc),
      .pred_result (pred_result),
      .mispred_cnt (mispred_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Present a resolving branch; returns 1 time unit later (comb settled)
   task automatic drive_up(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic [31:0] pnpc, input logic e);
      up_valid    = 1'b1;
      up_pc       = pc;
      up_taken    = tk;
      up_target   = tgt;
      up_pred_npc = pnpc;
      en          = e;
      #1;
   endtask

   // Advance one edge, then retire the branch
   task automatic tick();
      @(posedge CLK);
      #1;
      up_valid = 1'b0;
      en       = 1'b1;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                       input logic [31:0] npc);
      lk_pc = pc;
      #1;
      chk({tag, "_hit"}, 32'(lk_hit), 32'(hit));
      chk({tag, "_npc"}, lk_npc, npc);
   endtask

   initial begin
      nRST = 1'b1; en = 1'b0; lk_pc = 32'h40;
      up_valid = 1'b0; up_pc = '0; up_taken = 1'b0; up_target = '0; up_pred_npc = '0;
      #1 nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      // Reset state
      look("rst", 32'h40, 1'b0, 32'h44);
      chk("rst_pr", 32'(pred_result), 32'(NA));
      chk("rst_cnt", mispred_cnt, 32'd0);
      nRST = 1'b1;
      @(posedge CLK); #1;

      // First taken branch at 0x40 allocates; also same-cycle lookup sees miss
      lk_pc = 32'h40;
      drive_up(32'h40, 1'b1, 32'h80, 32'h44, 1'b1);
      chk("alloc_mp", 32'(mispredict), 32'd1);
      chk("alloc_fix", fix_pc, 32'h80);
      chk("alloc_pre_hit", 32'(lk_hit), 32'd0);
      tick();
      look("alloc", 32'h40, 1'b1, 32'h80);
      chk("alloc_tk", 32'(lk_taken), 32'd1);
      chk("alloc_pr", 32'(pred_result), 32'(WRONG_PRED));
      chk("alloc_cnt", mispred_cnt, 32'd1);

      // Three more taken: 10 -> 11 saturates, all predicted right
      for (int i = 0; i < 3; i++) begin
         drive_up(32'h40, 1'b1, 32'h80, 32'h80, 1'b1);
         chk("sat_mp", 32'(mispredict), 32'd0);
         tick();
      end
      chk("sat_pr", 32'(pred_result), 32'(RIGHT_PRED));
      chk("sat_cnt", mispred_cnt, 32'd1);
      // Not taken: 11 -> 10, still predicts taken
      drive_up(32'h40, 1'b0, 32'h80, 32'h80, 1'b1);
      chk("nt_mp", 32'(mispredict), 32'd1);
      chk("nt_fix", fix_pc, 32'h44);
      tick();
      look("nt", 32'h40, 1'b1, 32'h80);
      chk("nt_cnt", mispred_cnt, 32'd2);

      // Aliasing at index 0: 0x440 and 0x40 evict each other
      drive_up(32'h440, 1'b1, 32'h900, 32'h444, 1'b1);
      chk("al1_mp", 32'(mispredict), 32'd1);
      tick();
      look("al1_a", 32'h440, 1'b1, 32'h900);
      look("al1_b", 32'h40, 1'b0, 32'h44);
      chk("al1_cnt", mispred_cnt, 32'd3);
      drive_up(32'h40, 1'b1, 32'h80, 32'h44, 1'b1);
      chk("al2_mp", 32'(mispredict), 32'd1);
      tick();
      look("al2_a", 32'h40, 1'b1, 32'h80);
      look("al2_b", 32'h440, 1'b0, 32'h444);
      chk("al2_cnt", mispred_cnt, 32'd4);
      drive_up(32'h440, 1'b1, 32'h900, 32'h444, 1'b1);
      tick();
      look("al3", 32'h440, 1'b1, 32'h900);
      chk("al3_cnt", mispred_cnt, 32'd5);
      // Correct prediction leaves RIGHT_PRED behind
      drive_up(32'h440, 1'b1, 32'h900, 32'h900, 1'b1);
      chk("ok_mp", 32'(mispredict), 32'd0);
      tick();
      chk("ok_pr", 32'(pred_result), 32'(RIGHT_PRED));

      // en=0: decision driven, no state change
      drive_up(32'h104, 1'b1, 32'h200, 32'h108, 1'b0);
      chk("hold_mp", 32'(mispredict), 32'd1);
      chk("hold_fix", fix_pc, 32'h200);
      tick();
      look("hold", 32'h104, 1'b0, 32'h108);
      chk("hold_pr", 32'(pred_result), 32'(RIGHT_PRED));
      chk("hold_cnt", mispred_cnt, 32'd5);

      // Same-cycle lookup and update at 0x40 shows the old (aliased) entry
      lk_pc = 32'h40;
      drive_up(32'h40, 1'b1, 32'h80, 32'h44, 1'b1);
      chk("same_pre_hit", 32'(lk_hit), 32'd0);
      chk("same_pre_npc", lk_npc, 32'h44);
      tick();
      look("same_post", 32'h40, 1'b1, 32'h80);
      chk("same_cnt", mispred_cnt, 32'd6);

      // Async reset mid-cycle, away from any clock edge
      nRST = 1'b0;
      look("arst", 32'h40, 1'b0, 32'h44);
      chk("arst_cnt", mispred_cnt, 32'd0);
      chk("arst_pr", 32'(pred_result), 32'(NA));
      // PC arithmetic wraps at the top of the address space
      look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
      drive_up(32'hFFFF_FFFC, 1'b0, 32'h10, 32'h0, 1'b1);
      chk("wrap_fix", fix_pc, 32'h0);
      chk("wrap_mp", 32'(mispredict), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
